// File: rtl/bus_trace_pkg.sv
// bus_trace_pkg: shared definitions for the bus trace FIFO.
//   - kind encodings (KIND_RD, KIND_WR, KIND_COL)
//   - entry field widths and the packed entry typedef
//   - event_kind(): maps the wr/rd access pulses to a kind code
// Optional feature macro: BUS_TRACE_TIMESTAMP_EN adds a 16-bit timestamp
// field to each entry.
package bus_trace_pkg;

    localparam int KIND_W = 2;
    localparam int ADDR_W = 14;   // word address, bits [15:2]
    localparam int DATA_W = 32;
    localparam int TS_W   = 16;

    localparam logic [KIND_W-1:0] KIND_RD  = 2'b01;
    localparam logic [KIND_W-1:0] KIND_WR  = 2'b10;
    localparam logic [KIND_W-1:0] KIND_COL = 2'b11;

    typedef struct packed {
        logic [KIND_W-1:0] kind;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
`ifdef BUS_TRACE_TIMESTAMP_EN
        logic [TS_W-1:0]   ts;
`endif
    } trace_entry_t;

    localparam int ENTRY_W = $bits(trace_entry_t);

    // A cycle with both pulses is stored once, as a collision.
    function automatic logic [KIND_W-1:0] event_kind(input logic wr, input logic rd);
        logic [KIND_W-1:0] k;
        k = 2'b00;
        if (wr && rd)  k = KIND_COL;
        else if (wr)   k = KIND_WR;
        else if (rd)   k = KIND_RD;
        return k;
    endfunction

endpackage

// File: rtl/trace_fifo_mem.sv
// trace_fifo_mem: DEPTH x W storage, one synchronous write port and one
// asynchronous read port. Contents are not reset.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - combinational read data at raddr
module trace_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bus_trace_fifo.sv
// bus_trace_fifo: captures filtered bus accesses into a first-word-fall-through
// trace FIFO with overflow tracking.
// Ports:
//   ACLK, ARESETN             - clock, asynchronous active-low reset
//   wr_en, rd_en              - single-cycle access pulses from the bus tap
//   addr_in, data_in          - access word address and data
//   cap_en                    - capture enable
//   clear                     - synchronous flush (FIFO, flags, timestamp)
//   filt_en/filt_addr/filt_mask - address filter: match when masked bits equal
//   pop                       - consume the head entry
//   out_valid                 - FIFO non-empty; qualifies out_kind/addr/data/ts
//   out_kind/out_addr/out_data/out_ts - head entry fields
//   level                     - entry count 0..DEPTH
//   overflow, drop_cnt        - sticky drop flag and saturating drop count
// Optional feature macro: BUS_TRACE_TIMESTAMP_EN (free-running 16-bit
// timestamp stored per entry; out_ts is 0 when undefined).
//
// Consumer handshake: out_valid is the valid, pop is the ready. The head
// advances at an edge where pop=1 and out_valid=1; pop with out_valid=0 is
// ignored, and the head fields never change while out_valid=1 without pop.
module bus_trace_fifo
    import bus_trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [15:2]            addr_in,
    input  logic [31:0]            data_in,
    input  logic                   cap_en,
    input  logic                   clear,
    input  logic                   filt_en,
    input  logic [15:2]            filt_addr,
    input  logic [15:2]            filt_mask,
    input  logic                   pop,
    output logic                   out_valid,
    output logic [1:0]             out_kind,
    output logic [15:2]            out_addr,
    output logic [31:0]            out_data,
    output logic [15:0]            out_ts,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     level_q;
    logic              overflow_q;
    logic [DROP_W-1:0] drop_q;

    logic              addr_match;
    logic              trace_event;
    logic              is_full;
    logic              do_pop;
    logic              do_push;
    logic              do_drop;

    trace_entry_t      wr_entry;
    trace_entry_t      rd_entry;
    trace_entry_t      hold_entry;
    trace_entry_t      head;
    logic [ENTRY_W-1:0] rd_word;

`ifdef BUS_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]   ts_cnt;
`endif

    assign addr_match  = !filt_en || (((addr_in ^ filt_addr) & filt_mask) == '0);
    assign trace_event = (wr_en || rd_en) && cap_en && addr_match;
    assign is_full     = (level_q == FULL_LEVEL);
    assign do_pop      = pop && (level_q != '0);
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign do_push     = trace_event && (!is_full || do_pop);
    assign do_drop     = trace_event && is_full && !do_pop;

    always_comb begin
        wr_entry      = '0;
        wr_entry.kind = event_kind(wr_en, rd_en);
        wr_entry.addr = addr_in;
        wr_entry.data = data_in;
`ifdef BUS_TRACE_TIMESTAMP_EN
        wr_entry.ts   = ts_cnt;
`endif
    end

    trace_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_mem (
        .clk   (ACLK),
        .we    (do_push && !clear),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    assign rd_entry = rd_word;

    // Pointers, level and drop tracking; clear overrides any push or pop.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            if (do_drop) begin
                overflow_q <= 1'b1;
                if (drop_q != '1) drop_q <= drop_q + DROP_W'(1);
            end
        end
    end

    // The read slot goes stale once the FIFO drains, so the last presented
    // head is kept here to hold the output fields while out_valid=0.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)       hold_entry <= '0;
        else if (out_valid) hold_entry <= rd_entry;
    end

`ifdef BUS_TRACE_TIMESTAMP_EN
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)   ts_cnt <= '0;
        else if (clear) ts_cnt <= '0;
        else            ts_cnt <= ts_cnt + TS_W'(1);
    end
`endif

    assign out_valid = (level_q != '0);
    assign head      = out_valid ? rd_entry : hold_entry;
    assign out_kind  = head.kind;
    assign out_addr  = head.addr;
    assign out_data  = head.data;
`ifdef BUS_TRACE_TIMESTAMP_EN
    assign out_ts    = head.ts;
`else
    assign out_ts    = '0;
`endif
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_bus_trace_fifo.sv
// tb_bus_trace_fifo: self-checking bench for bus_trace_fifo (DEPTH=16).
// Inputs are driven at the falling edge; outputs are sampled at the next
// falling edge. A queue holds the expected FIFO contents.
// Optional feature macro: BUS_TRACE_TIMESTAMP_EN (enables timestamp checks).
module tb_bus_trace_fifo;

  localparam int DEPTH = 16;
  localparam int LW    = 5;

  logic          ACLK;
  logic          ARESETN;
  logic          wr_en, rd_en;
  logic [15:2]   addr_in;
  logic [31:0]   data_in;
  logic          cap_en, clear, filt_en;
  logic [15:2]   filt_addr, filt_mask;
  logic          pop;
  logic          out_valid;
  logic [1:0]    out_kind;
  logic [15:2]   out_addr;
  logic [31:0]   out_data;
  logic [15:0]   out_ts;
  logic [LW-1:0] level;
  logic          overflow;
  logic [15:0]   drop_cnt;

  // expected entry layout: {kind[1:0], addr[13:0], data[31:0], ts[15:0]}
  logic [63:0] exp_q[$];
  logic [15:0] exp_drop;
  logic        exp_ovf;
  int          n_checks;
  int          n_bad;

  bus_trace_fifo #(.DEPTH(DEPTH), .DROP_W(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .wr_en(wr_en), .rd_en(rd_en), .addr_in(addr_in), .data_in(data_in),
    .cap_en(cap_en), .clear(clear),
    .filt_en(filt_en), .filt_addr(filt_addr), .filt_mask(filt_mask),
    .pop(pop),
    .out_valid(out_valid), .out_kind(out_kind), .out_addr(out_addr),
    .out_data(out_data), .out_ts(out_ts),
    .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  // clock / reset
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

`ifdef BUS_TRACE_TIMESTAMP_EN
  // reference timestamp: cycles since reset or clear
  logic [15:0] tb_ts;
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)   tb_ts <= '0;
    else if (clear) tb_ts <= '0;
    else            tb_ts <= tb_ts + 16'd1;
  end
`endif

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state();
    check_val("valid", 64'(out_valid), 64'(exp_q.size() != 0));
    check_val("level", 64'(level), 64'(exp_q.size()));
    check_val("ovf", 64'(overflow), 64'(exp_ovf));
    check_val("drop", 64'(drop_cnt), 64'(exp_drop));
    if (exp_q.size() > 0)
      check_val("head", {out_kind, out_addr, out_data, out_ts}, exp_q[0]);
  endtask

  // driver: one cycle of stimulus from a falling edge to the next, with
  // the expected-queue update for that edge.
  task automatic cycle(input logic wr, input logic rd, input logic [13:0] a,
                       input logic [31:0] d, input logic p, input logic c);
    logic       ev, pp, full;
    logic [1:0] k;
    logic [15:0] ts_exp;
    wr_en = wr; rd_en = rd; addr_in = a; data_in = d; pop = p; clear = c;
    ev = (wr || rd) && cap_en && (!filt_en || (((a ^ filt_addr) & filt_mask) == 14'h0));
    k = (wr && rd) ? 2'b11 : (wr ? 2'b10 : 2'b01);
`ifdef BUS_TRACE_TIMESTAMP_EN
    ts_exp = tb_ts;
`else
    ts_exp = 16'h0;
`endif
    if (c) begin
      exp_q.delete();
      exp_drop = 16'h0;
      exp_ovf  = 1'b0;
    end else begin
      pp   = p && (exp_q.size() > 0);
      full = (exp_q.size() == DEPTH);
      if (pp) void'(exp_q.pop_front());
      if (ev && (!full || pp)) exp_q.push_back({k, a, d, ts_exp});
      else if (ev) begin
        exp_ovf = 1'b1;
        if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
      end
    end
    @(negedge ACLK);
    wr_en = 1'b0; rd_en = 1'b0; pop = 1'b0; clear = 1'b0;
    check_state();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    cycle(1'b0, 1'b0, 14'h0, 32'h0, 1'b1, 1'b0);
  endtask

  logic [31:0] first_data, new_data;
  logic        r_wr, r_rd, r_pop, r_clr;
  logic [15:0] t0;

  initial begin
    n_checks = 0; n_bad = 0;
    exp_drop = 16'h0; exp_ovf = 1'b0;
    ARESETN = 1'b0;
    wr_en = 0; rd_en = 0; addr_in = '0; data_in = '0; cap_en = 0; clear = 0;
    filt_en = 0; filt_addr = '0; filt_mask = '0; pop = 0;
    repeat (3) @(negedge ACLK);

    // reset state
    check_val("rst_valid", 64'(out_valid), 64'd0);
    check_val("rst_level", 64'(level), 64'd0);
    check_val("rst_ovf", 64'(overflow), 64'd0);
    check_val("rst_drop", 64'(drop_cnt), 64'd0);
    check_val("rst_ts", 64'(out_ts), 64'd0);
    ARESETN = 1'b1;
    cap_en  = 1'b1;
    repeat (10) idle();

    // basic write capture at timestamp 10
    cycle(1'b1, 1'b0, 14'h048D, 32'hDEADBEEF, 1'b0, 1'b0);
    check_val("wr_kind", 64'(out_kind), 64'h2);
    check_val("wr_addr", 64'(out_addr), 64'h048D);
    check_val("wr_data", 64'(out_data), 64'hDEADBEEF);
`ifdef BUS_TRACE_TIMESTAMP_EN
    check_val("wr_ts10", 64'(out_ts), 64'd10);
`else
    check_val("wr_ts0", 64'(out_ts), 64'd0);
`endif
    pop_one();
    check_val("hold_data", 64'(out_data), 64'hDEADBEEF);
    pop_one();  // pop on empty is ignored

    // address filter
    filt_en = 1'b1; filt_addr = 14'h0040; filt_mask = 14'h0FC0;
    cycle(1'b0, 1'b1, 14'h0041, 32'h11110104, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 14'h0081, 32'h22220204, 1'b0, 1'b0);
    check_val("filt_level", 64'(level), 64'd1);
    check_val("filt_addr", 64'(out_addr), 64'h0041);
    pop_one();
    filt_en = 1'b0;

    // overflow: 20 writes into a 16-deep FIFO
    for (int i = 0; i < 20; i++) begin
      new_data = $urandom();
      if (i == 0) first_data = new_data;
      cycle(1'b1, 1'b0, 14'(i), new_data, 1'b0, 1'b0);
    end
    check_val("ovf_level", 64'(level), 64'd16);
    check_val("ovf_flag", 64'(overflow), 64'd1);
    check_val("ovf_drop", 64'(drop_cnt), 64'd4);
    check_val("ovf_head", 64'(out_data), 64'(first_data));

    // full with simultaneous pop: accepted, read out 16th
    new_data = 32'hC0FFEE01;
    cycle(1'b1, 1'b0, 14'h3ABC, new_data, 1'b1, 1'b0);
    check_val("fullpop_level", 64'(level), 64'd16);
    check_val("fullpop_drop", 64'(drop_cnt), 64'd4);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check_val("fullpop_16th", 64'(out_data), 64'(new_data));
      pop_one();
    end

    // collision, then clear with a simultaneous event
    cycle(1'b1, 1'b1, 14'h0123, 32'hA5A5A5A5, 1'b0, 1'b0);
    check_val("col_kind", 64'(out_kind), 64'h3);
    check_val("col_level", 64'(level), 64'd1);
    cycle(1'b1, 1'b0, 14'h0222, 32'h5A5A5A5A, 1'b1, 1'b1);
    check_val("clr_level", 64'(level), 64'd0);
    check_val("clr_drop", 64'(drop_cnt), 64'd0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      cap_en    = ($urandom_range(0, 9) != 0);
      filt_en   = ($urandom_range(0, 3) == 0);
      filt_addr = 14'($urandom_range(0, 15));
      filt_mask = 14'h000C;
      r_wr  = $urandom_range(0, 1) == 1;
      r_rd  = $urandom_range(0, 2) == 0;
      r_pop = $urandom_range(0, 2) == 0;
      r_clr = $urandom_range(0, 60) == 0;
      cycle(r_wr, r_rd, 14'($urandom_range(0, 15)), $urandom(), r_pop, r_clr);
    end
    cap_en = 1'b1; filt_en = 1'b0;

    // asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 14'(i), 32'(i + 100), 1'b0, 1'b0);
    @(posedge ACLK);
    #2 ARESETN = 1'b0;
    #1;
    check_val("arst_valid", 64'(out_valid), 64'd0);
    check_val("arst_level", 64'(level), 64'd0);
    exp_q.delete(); exp_drop = 16'h0; exp_ovf = 1'b0;
    @(negedge ACLK);
    check_state();
    ARESETN = 1'b1;
    idle();
    cycle(1'b0, 1'b1, 14'h0777, 32'h0BADF00D, 1'b0, 1'b0);
    pop_one();

`ifdef BUS_TRACE_TIMESTAMP_EN
    // timestamp wrap
    t0 = tb_ts;
    repeat (65540) @(negedge ACLK);
    cycle(1'b1, 1'b0, 14'h0001, 32'h00000001, 1'b0, 1'b0);
    check_val("ts_wrap", 64'(out_ts), 64'(16'(t0 + 16'd65540)));
    pop_one();
`else
    t0 = 16'h0;
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
